reg_scoreboard: RTL
===================

# reg_scoreboard

Per-register pending-write tracker for the 32×64 register file in the pipelined CPU. It sits between decode/issue and writeback. It counts outstanding writes to each architectural register and asserts a combinational stall when an issuing instruction reads a register with a write still in flight. It also stalls when the destination's pending counter is saturated. X31 is the hardwired zero register and is never tracked.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers.
- CNT_W, 2, pending-write counter width per register; max outstanding per register = 2^CNT_W − 1.
- ZERO_REG, 31, index of the hardwired zero register.

Ports:
- clk  input  1  the single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- issue_valid  input  1  the instruction in decode requests issue this cycle.
- issue_rn  input  5  first source register index.
- issue_rn_used  input  1  the instruction reads issue_rn.
- issue_rm  input  5  second source register index.
- issue_rm_used  input  1  the instruction reads issue_rm.
- issue_rd  input  5  destination register index.
- issue_rd_used  input  1  the instruction writes issue_rd.
- wb_valid  input  1  a register write retires this cycle (same cycle as the register file write enable).
- wb_rd  input  5  register index being written back.
- issue_stall  output  1  combinational; hold decode this cycle.
- issue_accept  output  1  combinational; equals issue_valid & ~issue_stall.
- busy  output  32  registered; bit i = pending count of register i ≠ 0.
- idle  output  1  registered; all counts zero.
- underflow_err  output  1  registered, sticky; a writeback arrived for a register with count 0.

## Operation
- State: NUM_REGS counters of CNT_W bits. The ZERO_REG counter is constant 0 and no logic is built for it.
- Source hazard, RAW: (issue_rn_used & cnt[issue_rn] ≠ 0) | (issue_rm_used & cnt[issue_rm] ≠ 0). A source equal to ZERO_REG never hazards.
- Saturation hazard: issue_rd_used & issue_rd ≠ ZERO_REG & cnt[issue_rd] == max.
- issue_stall = issue_valid & (source hazard | saturation hazard). Stall is 0 when issue_valid is 0.
- Increment: issue_accept & issue_rd_used & issue_rd ≠ ZERO_REG → cnt[issue_rd] += 1.
- Decrement: wb_valid & wb_rd ≠ ZERO_REG & cnt[wb_rd] ≠ 0 → cnt[wb_rd] −= 1.
- Writeback with wb_rd = ZERO_REG is ignored.
- Underflow: wb_valid & wb_rd ≠ ZERO_REG & cnt[wb_rd] == 0 → the count stays 0 and underflow_err is set. It clears only on reset.
- Simultaneous increment and decrement on the same register: the net count is unchanged. The underflow check uses the pre-update count, so count 0 with a same-cycle increment and writeback still flags underflow and ends at 1.
- WAW is permitted up to saturation. Writeback order is the pipeline's responsibility.

## Timing
- Reset values: all counts 0, busy = 0, idle = 1, underflow_err = 0. issue_stall and issue_accept follow their combinational equations from the cleared state.
- While reset is high, issue and writeback inputs are ignored. Reset mid-operation discards all pending state on the next posedge.
- Counter, busy, idle and underflow_err update on the posedge following the triggering inputs.
- issue_stall and issue_accept have zero-cycle latency from inputs and current counts. There is no internal path from issue_stall back to the inputs.
- Minimum back-to-back dependency, no bypass: a producer accepted in cycle N, with its writeback in cycle W, lets the dependent consumer issue no earlier than cycle W+1.

## Configuration
- Macro SCOREBOARD_WB_BYPASS_EN:
  - Defined: the source hazard uses the effective count cnt[r] − (wb_valid & wb_rd == r & cnt[r] ≠ 0). A consumer can therefore issue in the same cycle as the final writeback of its source. This relies on the register file's write-before-read forwarding.
  - Undefined: the hazard uses the registered count only, and the consumer issues at cycle W+1.
  - The saturation hazard and the busy output are identical in both builds.

## Test plan
- Reset, then idle: busy = 0, idle = 1, issue_valid with rn = 3 → issue_stall = 0, issue_accept = 1.
- RAW: accept rd = 5, next cycle issue rn = 5 → stall = 1. With wb_rd = 5 in cycle W:
  - without the macro, stall = 1 in W and 0 in W+1;
  - with the macro, stall = 0 in W.
- Saturation (CNT_W = 2): three accepts to rd = 7 → busy[7] = 1 and a fourth issue with rd = 7 stalls. One wb_rd = 7 → the fourth issue is accepted.
- Zero register: issue rd = 31 and wb_rd = 31 repeatedly → busy[31] = 0, idle = 1, no stall on rn = 31, underflow_err = 0.
- Simultaneous events: count[2] = 1, accept rd = 2 and wb_rd = 2 in the same cycle → count stays 1 and busy[2] = 1. Then wb_rd = 9 with count 0 → underflow_err = 1 and stays 1 until reset.
- Reset mid-operation: counts nonzero on registers 1, 4 and 10, assert reset one cycle → busy = 0, idle = 1, underflow_err = 0.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback handshake bundle between decode/issue, writeback and the
// register scoreboard. The decode side is the master; the scoreboard is the slave.
interface reg_scoreboard_if #(
    parameter int IDX_W = 5
);
    logic             issue_valid;
    logic [IDX_W-1:0] issue_rn;
    logic             issue_rn_used;
    logic [IDX_W-1:0] issue_rm;
    logic             issue_rm_used;
    logic [IDX_W-1:0] issue_rd;
    logic             issue_rd_used;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_rd;
    logic             issue_stall;
    logic             issue_accept;

    modport master (
        output issue_valid, issue_rn, issue_rn_used, issue_rm, issue_rm_used,
               issue_rd, issue_rd_used, wb_valid, wb_rd,
        input  issue_stall, issue_accept
    );

    modport slave (
        input  issue_valid, issue_rn, issue_rn_used, issue_rm, issue_rm_used,
               issue_rd, issue_rd_used, wb_valid, wb_rd,
        output issue_stall, issue_accept
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard with combinational RAW/saturation stall.
// Optional SCOREBOARD_WB_BYPASS_EN lets a source clear on its final same-cycle writeback.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    reg_scoreboard_if.slave     sb,
    output logic [NUM_REGS-1:0] busy,
    output logic                idle,
    output logic                underflow_err
);
    localparam int              IDX_W   = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0] src_pending;
    logic [NUM_REGS-1:0] sat;
    logic [NUM_REGS-1:0] uf_hit;
    logic [NUM_REGS-1:0] nonzero_next;
    logic                rn_hazard;
    logic                rm_hazard;
    logic                rd_sat;
    logic                stall;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                assign src_pending[gi]  = 1'b0;
                assign sat[gi]          = 1'b0;
                assign uf_hit[gi]       = 1'b0;
                assign nonzero_next[gi] = 1'b0;
            end else begin : g_track
                logic [CNT_W-1:0] cnt_reg;
                logic [CNT_W-1:0] cnt_next;
                logic             wb_hit;
                logic             inc;
                logic             dec;

                assign wb_hit = sb.wb_valid & (sb.wb_rd == IDX_W'(gi));
                assign inc    = sb.issue_accept & sb.issue_rd_used & (sb.issue_rd == IDX_W'(gi));
                // An empty counter never decrements; that case is reported as underflow instead.
                assign dec    = wb_hit & (cnt_reg != '0);

                always_comb begin
                    cnt_next = cnt_reg;
                    if (inc && !dec) begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end else if (dec && !inc) begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                assign uf_hit[gi]       = wb_hit & (cnt_reg == '0);
                assign sat[gi]          = (cnt_reg == CNT_MAX);
                assign nonzero_next[gi] = (cnt_next != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
                // The final outstanding write landing this cycle is forwarded by the register file.
                assign src_pending[gi]  = (cnt_reg != '0) & ~(wb_hit & (cnt_reg == CNT_ONE));
`else
                assign src_pending[gi]  = (cnt_reg != '0);
`endif
            end
        end
    endgenerate

    assign rn_hazard = sb.issue_rn_used & src_pending[sb.issue_rn];
    assign rm_hazard = sb.issue_rm_used & src_pending[sb.issue_rm];
    assign rd_sat    = sb.issue_rd_used & sat[sb.issue_rd];
    assign stall     = sb.issue_valid & (rn_hazard | rm_hazard | rd_sat);

    assign sb.issue_stall  = stall;
    assign sb.issue_accept = sb.issue_valid & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy          <= '0;
            idle          <= 1'b1;
            underflow_err <= 1'b0;
        end else begin
            busy          <= nonzero_next;
            idle          <= ~|nonzero_next;
            underflow_err <= underflow_err | (|uf_hit);
        end
    end
endmodule
